// File: rtl/sha256_hash_core.sv
// sha256_hash_core: iterative SHA-256 / SHA-224 compression engine.
// Compresses one pre-padded 512-bit block per command, one round per clock.
// init loads the IV selected by mode; next chains onto the current H state.
// Optional feature macro SHA256_BLOCK_CNT_EN adds a 16-bit completed-block counter.
module sha256_hash_core (
   input  logic         clk,
   input  logic         reset,
   input  logic         init,
   input  logic         next,
   input  logic         mode,
   input  logic [511:0] block,
   output logic         ready,
   output logic [255:0] digest,
   output logic         digest_valid
`ifdef SHA256_BLOCK_CNT_EN
   ,
   output logic [15:0]  block_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, ROUNDS, DONE} state_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic logic [31:0] small_s0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_s1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   state_t      state;
   state_t      state_nxt;
   logic [31:0] h_reg [8];   // chaining state H0..H7
   logic [31:0] v     [8];   // working variables a..h
   logic [31:0] w     [16];  // w[0] is the schedule word for the current round
   logic [5:0]  round;
   logic        is_next;

   logic [31:0] t1;
   logic [31:0] t2;
   logic [31:0] w_new;
   logic [31:0] ch;
   logic [31:0] maj;

   assign ready  = (state == IDLE);
   assign digest = {h_reg[0], h_reg[1], h_reg[2], h_reg[3],
                    h_reg[4], h_reg[5], h_reg[6], h_reg[7]};

   // Round function and schedule expansion for the current window position
   always_comb begin
      ch    = (v[4] & v[5]) ^ (~v[4] & v[6]);
      maj   = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t1    = v[7] + big_s1(v[4]) + ch + K[round] + w[0];
      t2    = big_s0(v[0]) + maj;
      w_new = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
   end

   // Next-state logic: accept a command only in IDLE, 64 rounds, one finalize cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (init || next) state_nxt = ROUNDS;
         ROUNDS:  if (round == 6'd63) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Datapath: load on command, one round per ROUNDS cycle, feed-forward add in DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            h_reg[i] <= '0;
            v[i]     <= '0;
         end
         for (int i = 0; i < 16; i++) w[i] <= '0;
         round        <= '0;
         is_next      <= 1'b0;
         digest_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (init || next) begin
                  for (int i = 0; i < 16; i++) w[i] <= block[511 - 32*i -: 32];
                  round        <= '0;
                  digest_valid <= 1'b0;
                  is_next      <= ~init;
                  if (init) begin
                     for (int i = 0; i < 8; i++) begin
                        h_reg[i] <= mode ? IV256[i] : IV224[i];
                        v[i]     <= mode ? IV256[i] : IV224[i];
                     end
                  end else begin
                     for (int i = 0; i < 8; i++) v[i] <= h_reg[i];
                  end
               end
            end
            ROUNDS: begin
               v[0] <= t1 + t2;
               v[1] <= v[0];
               v[2] <= v[1];
               v[3] <= v[2];
               v[4] <= v[3] + t1;
               v[5] <= v[4];
               v[6] <= v[5];
               v[7] <= v[6];
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= w_new;
               round <= round + 6'd1;
            end
            DONE: begin
               for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + v[i];
               digest_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SHA256_BLOCK_CNT_EN
   // Completed-block counter: restarts at 1 for init, wraps on next
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         block_cnt <= '0;
      end else if (state == DONE) begin
         block_cnt <= is_next ? block_cnt + 16'd1 : 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sha256_hash_core.sv
// tb_sha256_hash_core: directed test of sha256_hash_core with known-answer digests.
// Optional feature macro SHA256_BLOCK_CNT_EN also enables block counter checks.
module tb_sha256_hash_core;

   logic         clk;
   logic         reset;
   logic         init;
   logic         next;
   logic         mode;
   logic [511:0] block;
   logic         ready;
   logic [255:0] digest;
   logic         digest_valid;
`ifdef SHA256_BLOCK_CNT_EN
   logic [15:0]  block_cnt;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_TWO1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_TWO2 = {448'h0, 32'h00000000, 32'h000001c0};

   localparam logic [255:0] EXP_ABC  =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [223:0] EXP_224  =
      224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
   localparam logic [255:0] EXP_TWO  =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] EXP_ZERO =
      256'hda5698be17b9b46962335799779fbeca8ce5d491c0d26243bafef9ea1837a9d8;

   sha256_hash_core dut (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .next         (next),
      .mode         (mode),
      .block        (block),
      .ready        (ready),
      .digest       (digest),
      .digest_valid (digest_valid)
`ifdef SHA256_BLOCK_CNT_EN
      ,
      .block_cnt    (block_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one command, optionally pulse init+next at a given cycle, wait for ready.
   task automatic run_cmd(input logic do_init, input logic do_next, input logic m,
                          input logic [511:0] blk, input int pulse_at,
                          output logic rdy_after, output logic vld_after, output int cyc);
      @(negedge clk);
      init  = do_init;
      next  = do_next;
      mode  = m;
      block = blk;
      @(posedge clk);
      #1;
      init      = 1'b0;
      next      = 1'b0;
      block     = ~blk;
      mode      = ~m;
      rdy_after = ready;
      vld_after = digest_valid;
      cyc       = 0;
      while (ready !== 1'b1 && cyc < 200) begin
         if (cyc == pulse_at) begin
            init = 1'b1;
            next = 1'b1;
         end
         @(posedge clk);
         #1;
         init = 1'b0;
         next = 1'b0;
         cyc++;
      end
   endtask

   logic r0;
   logic v0;
   int   cyc;

   initial begin
      reset = 1'b1;
      init  = 1'b0;
      next  = 1'b0;
      mode  = 1'b0;
      block = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_ready", {255'h0, ready}, 256'h1);
      chk("reset_valid", {255'h0, digest_valid}, 256'h0);
      chk("reset_digest", digest, 256'h0);

      // SHA-256 "abc"
      run_cmd(1'b1, 1'b0, 1'b1, BLK_ABC, -1, r0, v0, cyc);
      chk("abc_ready_low", {255'h0, r0}, 256'h0);
      chk("abc_latency", 256'(cyc), 256'd65);
      chk("abc_valid", {255'h0, digest_valid}, 256'h1);
      chk("abc_digest", digest, EXP_ABC);
`ifdef SHA256_BLOCK_CNT_EN
      chk("abc_block_cnt", {240'h0, block_cnt}, 256'd1);
`endif

      // SHA-224 "abc"
      run_cmd(1'b1, 1'b0, 1'b0, BLK_ABC, -1, r0, v0, cyc);
      chk("abc224_valid_cleared", {255'h0, v0}, 256'h0);
      chk("abc224_latency", 256'(cyc), 256'd65);
      chk("abc224_digest", {digest[255:32], 32'h0}, {EXP_224, 32'h0});

      // Two-block message chained with next
      run_cmd(1'b1, 1'b0, 1'b1, BLK_TWO1, -1, r0, v0, cyc);
      chk("two_blk1_latency", 256'(cyc), 256'd65);
      run_cmd(1'b0, 1'b1, 1'b0, BLK_TWO2, -1, r0, v0, cyc);
      chk("two_blk2_ready_low", {255'h0, r0}, 256'h0);
      chk("two_blk2_latency", 256'(cyc), 256'd65);
      chk("two_digest", digest, EXP_TWO);
`ifdef SHA256_BLOCK_CNT_EN
      chk("two_block_cnt", {240'h0, block_cnt}, 256'd2);
`endif

      // Corner blocks
      run_cmd(1'b1, 1'b0, 1'b1, 512'h0, -1, r0, v0, cyc);
      chk("zero_ready_low", {255'h0, r0}, 256'h0);
      chk("zero_valid", {255'h0, digest_valid}, 256'h1);
      chk("zero_digest", digest, EXP_ZERO);

      run_cmd(1'b1, 1'b0, 1'b1, {512{1'b1}}, -1, r0, v0, cyc);
      chk("ones_ready_low", {255'h0, r0}, 256'h0);
      chk("ones_latency", 256'(cyc), 256'd65);
      chk("ones_valid", {255'h0, digest_valid}, 256'h1);
      chk("ones_no_x", {255'h0, $isunknown(digest)}, 256'h0);

      run_cmd(1'b1, 1'b0, 1'b1, {128{4'hA}}, -1, r0, v0, cyc);
      chk("aaaa_ready_low", {255'h0, r0}, 256'h0);
      chk("aaaa_valid", {255'h0, digest_valid}, 256'h1);
      chk("aaaa_no_x", {255'h0, $isunknown(digest)}, 256'h0);

      // init and next together in IDLE behave as init
      run_cmd(1'b1, 1'b1, 1'b1, BLK_ABC, -1, r0, v0, cyc);
      chk("both_digest", digest, EXP_ABC);

      // Commands pulsed mid-rounds and in the finalize cycle are ignored
      run_cmd(1'b0, 1'b1, 1'b0, BLK_ZERO_SEL(), 10, r0, v0, cyc);
      chk("pulse_rounds_latency", 256'(cyc), 256'd65);
      chk("pulse_rounds_valid", {255'h0, digest_valid}, 256'h1);
      run_cmd(1'b1, 1'b0, 1'b1, BLK_ABC, 64, r0, v0, cyc);
      chk("pulse_done_latency", 256'(cyc), 256'd65);
      chk("pulse_done_digest", digest, EXP_ABC);
      @(posedge clk);
      #1;
      chk("pulse_done_still_idle", {255'h0, ready}, 256'h1);
      chk("pulse_done_digest_hold", digest, EXP_ABC);

      run_cmd(1'b1, 1'b0, 1'b1, BLK_ABC, 10, r0, v0, cyc);
      chk("pulse_mid_latency", 256'(cyc), 256'd65);
      chk("pulse_mid_digest", digest, EXP_ABC);

      // Reset asserted during round 30
      @(negedge clk);
      init  = 1'b1;
      mode  = 1'b1;
      block = BLK_TWO1;
      @(posedge clk);
      #1;
      init = 1'b0;
      repeat (30) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midreset_ready", {255'h0, ready}, 256'h1);
      chk("midreset_valid", {255'h0, digest_valid}, 256'h0);
      chk("midreset_digest", digest, 256'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("postreset_ready", {255'h0, ready}, 256'h1);
      chk("postreset_digest", digest, 256'h0);

      // Engine fully usable after the abort
      run_cmd(1'b1, 1'b0, 1'b1, BLK_ABC, -1, r0, v0, cyc);
      chk("recover_digest", digest, EXP_ABC);
`ifdef SHA256_BLOCK_CNT_EN
      chk("recover_block_cnt", {240'h0, block_cnt}, 256'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // next on the "abc" result with a zero block; only its latency and validity are checked
   function automatic logic [511:0] BLK_ZERO_SEL();
      return 512'h0;
   endfunction

endmodule
